// File: rtl/hazard_ctrl.sv
// D-stage hazard control: tracks destination/Tnew of the instructions in E, M and W,
// and derives operand forwarding selects, the stall/flush request and a stall counter.
module hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs_addr,
    input  logic [4:0]  D_rt_addr,
    input  logic [1:0]  D_Tuse_rs,
    input  logic [1:0]  D_Tuse_rt,
    input  logic [4:0]  D_wa,
    input  logic [1:0]  D_Tnew,
    output logic [2:0]  s_D_rs_data,
    output logic [2:0]  s_D_rt_data,
    output logic        stall,
    output logic        E_flush,
    output logic [15:0] stall_cnt
);

    localparam int unsigned AW = 5;
    localparam int unsigned TW = 2;
    localparam int unsigned SW = 3;
    localparam int unsigned CW = 16;

    localparam logic [SW-1:0] SEL_ODATA = 3'b000;
    localparam logic [SW-1:0] SEL_EDATA = 3'b001;
    localparam logic [SW-1:0] SEL_MDATA = 3'b010;
    localparam logic [SW-1:0] SEL_WDATA = 3'b100;
    localparam logic [TW-1:0] TUSE_NONE = 2'd3;

    logic [AW-1:0] e_wa, m_wa, w_wa;
    logic [TW-1:0] e_tn, m_tn, w_tn;
    logic [SW:0]   rs_res, rt_res;

    // Youngest matching stage decides both the select and the hazard; result is {hazard, select}.
    function automatic logic [SW:0] resolve(
        input logic [AW-1:0] src,
        input logic [TW-1:0] tuse,
        input logic [AW-1:0] ewa,
        input logic [TW-1:0] etn,
        input logic [AW-1:0] mwa,
        input logic [TW-1:0] mtn,
        input logic [AW-1:0] wwa,
        input logic [TW-1:0] wtn
    );
        logic [SW-1:0] sel;
        logic          hz;
        sel = SEL_ODATA;
        hz  = 1'b0;
        if (src != '0) begin
            if (ewa == src) begin
                if (etn == '0) sel = SEL_EDATA;
                hz = (tuse != TUSE_NONE) && (etn > tuse);
            end else if (mwa == src) begin
                if (mtn == '0) sel = SEL_MDATA;
                hz = (tuse != TUSE_NONE) && (mtn > tuse);
            end else if ((wwa == src) && (wtn == '0)) begin
                sel = SEL_WDATA;
            end
        end
        return {hz, sel};
    endfunction

    function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] t);
        return (t == '0) ? '0 : TW'(t - TW'(1));
    endfunction

    always_comb begin
        rs_res      = resolve(D_rs_addr, D_Tuse_rs, e_wa, e_tn, m_wa, m_tn, w_wa, w_tn);
        rt_res      = resolve(D_rt_addr, D_Tuse_rt, e_wa, e_tn, m_wa, m_tn, w_wa, w_tn);
        s_D_rs_data = rs_res[SW-1:0];
        s_D_rt_data = rt_res[SW-1:0];
        stall       = rs_res[SW] | rt_res[SW];
        E_flush     = stall;
    end

    // Shadow pipeline shift; a stalled D instruction enters E as a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_wa      <= '0;
            e_tn      <= '0;
            m_wa      <= '0;
            m_tn      <= '0;
            w_wa      <= '0;
            w_tn      <= '0;
            stall_cnt <= '0;
        end else begin
            if (stall) begin
                e_wa <= '0;
                e_tn <= '0;
            end else begin
                e_wa <= D_wa;
                e_tn <= D_Tnew;
            end
            m_wa <= e_wa;
            m_tn <= dec_sat(e_tn);
            w_wa <= m_wa;
            w_tn <= dec_sat(m_tn);
            if (stall && (stall_cnt != '1)) stall_cnt <= CW'(stall_cnt + CW'(1));
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, randomized run against an
// age-based pipeline model, and stall counter saturation.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  D_rs_addr, D_rt_addr, D_wa;
    logic [1:0]  D_Tuse_rs, D_Tuse_rt, D_Tnew;
    logic [2:0]  s_D_rs_data, s_D_rt_data;
    logic        stall, E_flush;
    logic [15:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .D_rs_addr  (D_rs_addr),
        .D_rt_addr  (D_rt_addr),
        .D_Tuse_rs  (D_Tuse_rs),
        .D_Tuse_rt  (D_Tuse_rt),
        .D_wa       (D_wa),
        .D_Tnew     (D_Tnew),
        .s_D_rs_data(s_D_rs_data),
        .s_D_rt_data(s_D_rt_data),
        .stall      (stall),
        .E_flush    (E_flush),
        .stall_cnt  (stall_cnt)
    );

    typedef struct {
        logic        rst;
        logic [4:0]  rs;
        logic [1:0]  urs;
        logic [4:0]  rt;
        logic [1:0]  urt;
        logic [4:0]  wa;
        logic [1:0]  tn;
        logic [2:0]  ers;
        logic [2:0]  ert;
        logic        est;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vt[32];

    // Model: instruction that entered E a cycles ago sits at age a (0=E,1=M,2=W).
    logic [4:0] h_wa[3];
    int         h_tn[3];
    int         m_cnt;

    function automatic vec_t v(input logic r, input logic [4:0] rs, input logic [1:0] urs,
                               input logic [4:0] rt, input logic [1:0] urt,
                               input logic [4:0] wa, input logic [1:0] tn,
                               input logic [2:0] ers, input logic [2:0] ert,
                               input logic est, input logic [15:0] ecnt);
        vec_t x;
        x.rst = r;  x.rs = rs; x.urs = urs; x.rt = rt; x.urt = urt;
        x.wa = wa;  x.tn = tn; x.ers = ers; x.ert = ert; x.est = est; x.ecnt = ecnt;
        return x;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic void model_eval(input logic [4:0] src, input int tuse,
                                       output int sel, output bit hz);
        sel = 0;
        hz  = 1'b0;
        if (src != 5'd0) begin
            for (int a = 0; a < 3; a++) begin
                if (h_wa[a] == src) begin
                    int rem;
                    rem = (h_tn[a] > a) ? h_tn[a] - a : 0;
                    if (a == 2)        sel = 4;
                    else if (rem == 0) sel = 1 << a;
                    if (a < 2 && tuse != 3 && rem > tuse) hz = 1'b1;
                    break;
                end
            end
        end
    endfunction

    initial begin
        int  ers, ert;
        bit  hrs, hrt, est;

        vt[0]  = v(1, 0,3, 0,3, 5,1, 0,0,0,0);
        vt[1]  = v(1, 0,3, 0,3, 5,1, 0,0,0,0);
        vt[2]  = v(0, 5,0, 5,0, 0,0, 0,0,0,0);
        vt[3]  = v(0, 0,3, 0,3, 8,1, 0,0,0,0);
        vt[4]  = v(0, 8,0, 0,3, 0,0, 0,0,1,0);
        vt[5]  = v(0, 8,0, 0,3, 0,0, 2,0,0,1);
        vt[6]  = v(0, 0,3, 0,3, 9,2, 0,0,0,1);
        vt[7]  = v(0, 0,3, 9,1, 0,0, 0,0,1,1);
        vt[8]  = v(0, 0,3, 9,1, 0,0, 0,0,0,2);
        vt[9]  = v(0, 0,3, 9,1, 0,0, 0,4,0,2);
        vt[10] = v(0, 0,3, 0,3, 9,2, 0,0,0,2);
        vt[11] = v(0, 0,3, 9,0, 0,0, 0,0,1,2);
        vt[12] = v(0, 0,3, 9,0, 0,0, 0,0,1,3);
        // the load has reached W by the time both stall cycles are over
        vt[13] = v(0, 0,3, 9,0, 0,0, 0,4,0,4);
        vt[14] = v(0, 0,3, 0,3, 10,1, 0,0,0,4);
        vt[15] = v(0, 0,3, 0,3, 0,0, 0,0,0,4);
        vt[16] = v(0, 0,3, 0,3, 0,0, 0,0,0,4);
        vt[17] = v(0, 10,0, 0,3, 0,0, 4,0,0,4);
        vt[18] = v(0, 0,3, 0,3, 8,1, 0,0,0,4);
        vt[19] = v(0, 0,3, 0,3, 8,0, 0,0,0,4);
        vt[20] = v(0, 8,0, 8,3, 0,0, 1,1,0,4);
        vt[21] = v(0, 0,0, 0,0, 0,2, 0,0,0,4);
        vt[22] = v(0, 0,0, 0,0, 0,2, 0,0,0,4);
        vt[23] = v(0, 0,0, 0,0, 0,2, 0,0,0,4);
        vt[24] = v(0, 0,3, 0,3, 7,2, 0,0,0,4);
        vt[25] = v(0, 7,3, 7,1, 0,0, 0,0,1,4);
        vt[26] = v(0, 7,3, 7,1, 0,0, 0,0,0,5);
        vt[27] = v(0, 7,3, 7,1, 0,0, 4,4,0,5);
        vt[28] = v(0, 0,3, 0,3, 6,2, 0,0,0,5);
        vt[29] = v(0, 6,3, 0,3, 0,0, 0,0,0,5);
        vt[30] = v(1, 6,0, 0,3, 0,0, 0,0,1,5);
        vt[31] = v(0, 6,0, 0,3, 0,0, 0,0,0,0);

        reset = 1'b1;
        D_rs_addr = '0; D_rt_addr = '0; D_wa = '0;
        D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3; D_Tnew = '0;
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 32; i++) begin
            reset     = vt[i].rst;
            D_rs_addr = vt[i].rs;  D_Tuse_rs = vt[i].urs;
            D_rt_addr = vt[i].rt;  D_Tuse_rt = vt[i].urt;
            D_wa      = vt[i].wa;  D_Tnew    = vt[i].tn;
            @(negedge clk);
            check($sformatf("vec%0d_rs_sel", i), 32'(s_D_rs_data), 32'(vt[i].ers));
            check($sformatf("vec%0d_rt_sel", i), 32'(s_D_rt_data), 32'(vt[i].ert));
            check($sformatf("vec%0d_stall", i), 32'(stall), 32'(vt[i].est));
            check($sformatf("vec%0d_E_flush", i), 32'(E_flush), 32'(vt[i].est));
            check($sformatf("vec%0d_stall_cnt", i), 32'(stall_cnt), 32'(vt[i].ecnt));
            @(posedge clk); #1;
        end

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            reset     = (i == 0) || ($urandom_range(0, 63) == 0);
            D_rs_addr = 5'($urandom_range(0, 3));
            D_rt_addr = 5'($urandom_range(0, 3));
            D_wa      = 5'($urandom_range(0, 3));
            D_Tuse_rs = 2'($urandom_range(0, 3));
            D_Tuse_rt = 2'($urandom_range(0, 3));
            D_Tnew    = 2'($urandom_range(0, 2));
            @(negedge clk);
            if (i > 0) begin
                model_eval(D_rs_addr, int'(D_Tuse_rs), ers, hrs);
                model_eval(D_rt_addr, int'(D_Tuse_rt), ert, hrt);
                est = hrs | hrt;
                check("rnd_rs_sel", 32'(s_D_rs_data), 32'(ers));
                check("rnd_rt_sel", 32'(s_D_rt_data), 32'(ert));
                check("rnd_stall", 32'(stall), 32'(est));
                check("rnd_E_flush", 32'(E_flush), 32'(est));
                check("rnd_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
            end else begin
                est = 1'b0;
            end
            @(posedge clk);
            if (reset) begin
                for (int a = 0; a < 3; a++) begin h_wa[a] = '0; h_tn[a] = 0; end
                m_cnt = 0;
            end else begin
                if (est && m_cnt < 65535) m_cnt++;
                for (int a = 2; a > 0; a--) begin h_wa[a] = h_wa[a-1]; h_tn[a] = h_tn[a-1]; end
                h_wa[0] = est ? 5'd0 : D_wa;
                h_tn[0] = est ? 0 : int'(D_Tnew);
            end
            #1;
        end

        // Counter saturation with the stall request held high
        reset = 1'b1;
        D_rs_addr = '0; D_rt_addr = '0; D_wa = '0; D_Tnew = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        force dut.stall = 1'b1;
        for (int i = 1; i <= 70000; i++) begin
            @(posedge clk);
            if (i == 65534) begin
                #1;
                check("sat_ramp", 32'(stall_cnt), 32'd65534);
            end
        end
        #1;
        check("sat_hold", 32'(stall_cnt), 32'hFFFF);
        @(posedge clk); #1;
        check("sat_no_wrap", 32'(stall_cnt), 32'hFFFF);
        release dut.stall;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("sat_reset_clear", 32'(stall_cnt), 32'd0);
        check("sat_reset_stall", 32'(stall), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
